comb_sweep_driver: RTL and testbench
====================================

# comb_sweep_driver

Self-timed stimulus and capture stage for the 4-input combinational function block (`comb_func`). It sits directly around that block. It drives inputs `a`, `b`, `c`, `d` through all 16 combinations in ascending binary order, samples the function output `y` for each vector, and assembles a 16-bit truth table. It then compares the table against a golden value and reports per-vector mismatches plus a pass flag, so the function can be checked on silicon or in simulation without a hand-written stimulus list.

## Interface
Parameters:
- `SETTLE`, default 0: extra cycles each vector is held before `y` is sampled. Legal range 0..15. Each vector occupies `SETTLE+1` cycles.
- `EXPECTED`, default 16'h0000: golden truth table. Bit `i` is the expected `y` for vector `i = {a,b,c,d}`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a sweep. Sampled only in IDLE.
- `a`  out  1: function input, vector bit 3 (MSB).
- `b`  out  1: function input, vector bit 2.
- `c`  out  1: function input, vector bit 1.
- `d`  out  1: function input, vector bit 0 (LSB).
- `y`  in  1: function output, from `comb_func`.
- `busy`  out  1: high while in DRIVE.
- `done`  out  1: one-cycle pulse at sweep completion.
- `table_out`  out  16: captured truth table. Bit `i` holds `y` for vector `i`.
- `mismatch`  out  16: `table_out ^ EXPECTED`, registered at completion.
- `pass`  out  1: high when `mismatch == 0`, registered at completion.

## Operation
- The FSM has three states: IDLE, DRIVE and DONE.
- Reset drives every output and register low: `a`..`d`=0, `busy`=0, `done`=0, `table_out`=0, `mismatch`=0, `pass`=0. Internally, `idx`=0, `cnt`=0 and state = IDLE.
- IDLE + `start`=1: go to DRIVE with `idx`=0 and `cnt`=0. Clear `table_out`, `mismatch` and `pass`.
- IDLE + `start`=0: stay in IDLE. Results from the previous sweep are held.
- DRIVE, on each edge:
  - If `cnt == SETTLE`: capture `table_out[idx] <= y` and set `cnt <= 0`. If `idx == 15`, go to DONE; otherwise increment `idx`.
  - Otherwise: increment `cnt`.
- DONE: `done`=1 for exactly one cycle, then go to IDLE with `idx`=0.
- `{a,b,c,d}` are registered. They equal `idx` in DRIVE and are 4'b0000 in IDLE and DONE.
- `mismatch` and `pass` load on the DRIVE→DONE edge, using the final `table_out` including bit 15.
- `start` in DRIVE or DONE is ignored. It is not queued.
- `rst_n` low mid-sweep aborts the sweep immediately, since reset is asynchronous. All outputs go to their reset values. The next `start` restarts from vector 0000.
- `y` is treated as settled at the sample edge. There is no internal synchronisation of `y`, because it is in the same clock domain via combinational logic.

## Timing
- Edge E0 is the edge that samples `start`=1 in IDLE.
- Vector `i` is driven during cycles `i*(SETTLE+1)+1` through `(i+1)*(SETTLE+1)` after E0.
- `y` for vector `i` is captured at edge E`(i+1)*(SETTLE+1)`.
- The last capture and the DONE entry both occur at E`16*(SETTLE+1)`:
  - `done`, `mismatch` and `pass` become valid in the cycle after that edge.
  - `busy` falls at the same edge.
- With `SETTLE`=0, the sweep is 16 cycles of `busy` plus 1 cycle of `done`. The earliest restart is an IDLE `start` sampled one cycle after `done`.
- `cnt` is 4 bits wide and `idx` is 4 bits wide. Neither wraps inside a sweep: DRIVE exits at `idx`=15, `cnt`=`SETTLE`.

## Structure
- Package `comb_sweep_pkg` holds:
  - the `state_t` enum (IDLE, DRIVE, DONE),
  - `VEC_COUNT`=16,
  - `VEC_W`=4.
- Single module with no sub-module. The settle counter and vector index are inline registers.
- Top-level integration instantiates `comb_sweep_driver` and `comb_func` side by side, wiring `a`..`d` and `y`.

## Test plan
- **Reset:** assert `rst_n`=0 with no clock. Check all outputs are 0 and `a`..`d`=0000 immediately.
- **Basic sweep:** `SETTLE`=0, `EXPECTED`=16'hF000, `y` model = `a&b`, pulse `start`. Check:
  - `a`..`d` step 0000→1111, one vector per cycle.
  - `done` pulses 17 cycles after E0.
  - `table_out`=16'hF000, `mismatch`=0, `pass`=1.
- **Mismatch:** same setup but `y` model = `a|b`. Check `table_out`=16'hFFF0, `mismatch`=16'h0FF0, `pass`=0.
- **Settle hold:** `SETTLE`=3, `y` = `a^d`. Check:
  - each vector is held 4 cycles,
  - `busy` stays high for 64 cycles,
  - `done` pulses in cycle 65 after E0,
  - `table_out`=16'h55AA.
- **Start during sweep:** pulse `start` at vector 5 and again on the `done` cycle. Check there is no restart and no second `done`. A `start` one cycle later begins a fresh sweep, and `table_out` clears.
- **Reset mid-sweep:** drop `rst_n` while vector 7 is driven. Check outputs go to 0 asynchronously. After release, `start` yields a full 16-vector sweep from 0000 with correct results.

Source files
------------

// File: rtl/comb_sweep_pkg.sv
// Shared types and constants for the comb_func sweep driver.
package comb_sweep_pkg;

  localparam int unsigned VEC_COUNT = 16;
  localparam int unsigned VEC_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/comb_sweep_driver.sv
// Sweeps a 4-input combinational function through all 16 vectors, captures its
// truth table and compares it with a golden table.
module comb_sweep_driver
  import comb_sweep_pkg::*;
#(
  parameter int unsigned  SETTLE   = 0,
  parameter logic [15:0]  EXPECTED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        y,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [15:0] mismatch,
  output logic        pass
);

  localparam logic [3:0]       SettleCnt = SETTLE[3:0];
  localparam logic [VEC_W-1:0] LastIdx   = VEC_W'(VEC_COUNT - 1);

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       table_q, table_d;
  logic [15:0]       mismatch_q, mismatch_d;
  logic              pass_q, pass_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    table_d    = table_q;
    mismatch_d = mismatch_q;
    pass_d     = pass_q;

    case (state_q)
      IDLE: begin
        vec_d  = '0;
        busy_d = 1'b0;
        if (start) begin
          state_d    = DRIVE;
          idx_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          table_d    = '0;
          mismatch_d = '0;
          pass_d     = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == SettleCnt) begin
          table_d[idx_q] = y;
          cnt_d          = '0;
          if (idx_q == LastIdx) begin
            state_d    = DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            vec_d      = '0;
            // Compare against the table including the bit captured on this edge.
            mismatch_d = table_d ^ EXPECTED;
            pass_d     = (table_d == EXPECTED);
          end else begin
            idx_d = idx_q + 1'b1;
            vec_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
        vec_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
        vec_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      table_q    <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      table_q    <= table_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
    end
  end

  assign {a, b, c, d} = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign mismatch     = mismatch_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_comb_sweep_driver.sv
// Scoreboard bench for comb_sweep_driver: SETTLE=0 and SETTLE=3 instances.
module tb_comb_sweep_driver;

  typedef struct {
    logic [15:0] tbl;
    logic [15:0] mm;
    logic        pass;
    int          lat;
    int          c0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   mode0 = 0;

  exp_t q0[$];
  exp_t q3[$];

  // Instance 0: SETTLE=0, golden a&b
  logic        start0, a0, b0, c0, d0, y0, busy0, done0, pass0;
  logic [15:0] table0, mm0;
  // Instance 3: SETTLE=3, golden a^d
  logic        start3, a3, b3, c3, d3, y3, busy3, done3, pass3;
  logic [15:0] table3, mm3;

  assign y0 = (mode0 == 0) ? (a0 & b0) : (a0 | b0);
  assign y3 = a3 ^ d3;

  comb_sweep_driver #(.SETTLE(0), .EXPECTED(16'hF000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .a(a0), .b(b0), .c(c0), .d(d0), .y(y0),
    .busy(busy0), .done(done0), .table_out(table0), .mismatch(mm0), .pass(pass0)
  );

  comb_sweep_driver #(.SETTLE(3), .EXPECTED(16'h55AA)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .a(a3), .b(b3), .c(c3), .d(d3), .y(y3),
    .busy(busy3), .done(done3), .table_out(table3), .mismatch(mm3), .pass(pass3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop one expected result per done pulse.
  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected done at cycle %0d: got done=1 expected none", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("dut0 table_out", {16'h0, table0}, {16'h0, e.tbl});
        check("dut0 mismatch", {16'h0, mm0}, {16'h0, e.mm});
        check("dut0 pass", {31'h0, pass0}, {31'h0, e.pass});
        check("dut0 done latency", cyc - e.c0, e.lat);
        check("dut0 busy low at done", {31'h0, busy0}, 32'h0);
      end
    end
    if (done3 === 1'b1) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut3 unexpected done at cycle %0d: got done=1 expected none", cyc);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("dut3 table_out", {16'h0, table3}, {16'h0, e.tbl});
        check("dut3 mismatch", {16'h0, mm3}, {16'h0, e.mm});
        check("dut3 pass", {31'h0, pass3}, {31'h0, e.pass});
        check("dut3 done latency", cyc - e.c0, e.lat);
        check("dut3 busy low at done", {31'h0, busy3}, 32'h0);
      end
    end
  end

  // Pulse start0 for one cycle; returns in cycle 1 after E0.
  task automatic start_sweep0(input bit push, input logic [15:0] tbl, input logic [15:0] mm,
                              input logic pass);
    exp_t e;
    @(negedge clk);
    start0 = 1'b1;
    e.tbl = tbl; e.mm = mm; e.pass = pass; e.lat = 17; e.c0 = cyc;
    if (push) q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input int max);
    int n = 0;
    while (done0 !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("dut0 done within bound", {31'h0, done0}, 32'h1);
  endtask

  task automatic check_vectors0();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("dut0 vector %0d", i), {28'h0, a0, b0, c0, d0}, i);
      if (i == 0 || i == 15) check("dut0 busy", {31'h0, busy0}, 32'h1);
      if (i != 15) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dut0 outputs"}, {8'h0, a0, b0, c0, d0, busy0, done0, pass0, mm0[0], table0 | mm0},
          32'h0);
    check({tag, " dut3 outputs"}, {8'h0, a3, b3, c3, d3, busy3, done3, pass3, mm3[0], table3 | mm3},
          32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e3;
    start0 = 1'b0;
    start3 = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic sweep: y = a&b
    mode0 = 0;
    start_sweep0(1'b1, 16'hF000, 16'h0000, 1'b1);
    check_vectors0();
    wait_done0(4);
    check("dut0 vector zero at done", {28'h0, a0, b0, c0, d0}, 32'h0);
    @(negedge clk);

    // Mismatch sweep: y = a|b
    mode0 = 1;
    start_sweep0(1'b1, 16'hFFF0, 16'h0FF0, 1'b0);
    check_vectors0();
    wait_done0(4);
    @(negedge clk);
    mode0 = 0;

    // Settle hold on SETTLE=3 instance
    @(negedge clk);
    start3 = 1'b1;
    e3.tbl = 16'h55AA; e3.mm = 16'h0000; e3.pass = 1'b1; e3.lat = 65; e3.c0 = cyc;
    q3.push_back(e3);
    @(negedge clk);
    start3 = 1'b0;
    for (int j = 0; j < 64; j++) begin
      if (j % 4 == 0 || j % 4 == 3) begin
        check($sformatf("dut3 hold cycle %0d", j + 1), {28'h0, a3, b3, c3, d3}, j / 4);
        check($sformatf("dut3 busy cycle %0d", j + 1), {31'h0, busy3}, 32'h1);
      end
      @(negedge clk);
    end
    check("dut3 done in cycle 65", {31'h0, done3}, 32'h1);
    @(negedge clk);

    // Start during sweep and on the done cycle is ignored
    start_sweep0(1'b1, 16'hF000, 16'h0000, 1'b1);
    repeat (5) @(negedge clk);
    check("dut0 at vector 5", {28'h0, a0, b0, c0, d0}, 32'd5);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("dut0 no restart", {28'h0, a0, b0, c0, d0}, 32'd6);
    wait_done0(20);
    start0 = 1'b1;
    @(negedge clk);
    // Still high one cycle after done: this is the real restart in IDLE.
    begin
      exp_t e;
      e.tbl = 16'hF000; e.mm = 16'h0000; e.pass = 1'b1; e.lat = 17; e.c0 = cyc;
      q0.push_back(e);
    end
    @(negedge clk);
    start0 = 1'b0;
    check("dut0 table cleared on restart", {16'h0, table0}, 32'h0);
    check("dut0 pass cleared on restart", {31'h0, pass0}, 32'h0);
    check_vectors0();
    wait_done0(4);
    @(negedge clk);

    // Reset mid-sweep
    start_sweep0(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (7) @(negedge clk);
    check("dut0 at vector 7", {28'h0, a0, b0, c0, d0}, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    start_sweep0(1'b1, 16'hF000, 16'h0000, 1'b1);
    check_vectors0();
    wait_done0(4);

    repeat (20) @(negedge clk);
    check("dut0 scoreboard drained", q0.size(), 32'h0);
    check("dut3 scoreboard drained", q3.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
